// File: rtl/crtc_row_dma_ctrl.sv
// crtc_row_dma_ctrl: per-row VRAM -> CRTC row buffer DMA with bus request and
// a fixed post-burst holdoff that reproduces PC-8001 CPU wait timing.
module crtc_row_dma_ctrl #(
   parameter int          ROW_BYTES = 120,
   parameter int          HOLDOFF   = 1500,
   parameter logic [11:0] BASE_ADR  = 12'h300,
   parameter logic [4:0]  BANK      = 5'h0F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        row_start,
   input  logic        dma_en,
   input  logic        busack,
   output logic        busreq,
   output logic [16:0] ram_adr,
   input  logic [7:0]  ram_data,
   output logic        buf_we,
   output logic [6:0]  buf_adr,
   output logic [7:0]  buf_data,
   output logic        busy,
   output logic        overrun,
   input  logic        ovr_clr
);
   localparam int CW = $clog2(HOLDOFF + 2);
   typedef enum logic [2:0] {IDLE, REQ, ADDR, WRITE, HOLD} state_t;
   state_t          state_q, state_d;
   logic [11:0]     src_q, src_d;
   logic [6:0]      dst_q, dst_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            reload_q, reload_d, ovr_q, ovr_d;
   assign busy     = state_q != IDLE;
   assign busreq   = busy & dma_en;
   assign ram_adr  = {BANK, src_q};
   assign buf_we   = state_q == WRITE;
   assign buf_adr  = dst_q;
   assign buf_data = ram_data;
   assign overrun  = ovr_q;
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      cnt_d    = cnt_q;
      reload_d = reload_q | (busy & frame_start);
      case (state_q)
         IDLE: begin
            if (frame_start) src_d = BASE_ADR;
            if (row_start && dma_en) begin
               state_d = REQ;
               dst_d   = '0;
               cnt_d   = CW'(HOLDOFF);
            end else if (row_start) src_d = src_d + 12'(ROW_BYTES);
         end
         REQ: begin
            if (!dma_en) begin
               state_d = IDLE;
               src_d   = src_q + 12'(ROW_BYTES);
            end else if (busack) state_d = ADDR;
         end
         ADDR: begin
            src_d   = src_q + 12'd1;
            state_d = WRITE;
         end
         WRITE: begin
            dst_d   = dst_q + 7'd1;
            state_d = (dst_q == 7'(ROW_BYTES - 1)) ? HOLD : ADDR;
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase
      // a frame reload requested mid-burst lands when the sequence ends
      if (busy && state_d == IDLE) begin
         if (reload_d) src_d = BASE_ADR;
         reload_d = 1'b0;
      end
      ovr_d = (row_start & busy) | (ovr_q & ~ovr_clr);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         src_q    <= BASE_ADR;
         dst_q    <= '0;
         cnt_q    <= '0;
         reload_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         ovr_q    <= ovr_d;
      end
   end
endmodule
